// File: rtl/ccsds_axis_golden_checker.sv
// -----------------------------------------------------------------------------
// ccsds_axis_golden_checker
//
// Sink stage for the CCSDS 123.0-B-2 core output in self-test and bench tops.
// Joins the core's AXIS output with a golden-reference AXIS stream word by
// word. It counts compared words and mismatches, latches the first mismatch,
// checks the stream length against EXPECTED_WORDS, and runs a stall watchdog.
// The result is a sticky PASS / FAIL / TIMEOUT verdict.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   dut_data/valid/last, dut_ready   core output stream (sink side)
//   gold_data/valid, gold_ready      golden reference stream (sink side)
//   words_checked     compared transfers (saturating)
//   mismatches        mismatching transfers (saturating)
//   first_err_index   0-based index of the first mismatching word
//   first_err_dut     core word at the first mismatch
//   length_err        stream length differs from EXPECTED_WORDS
//   done              verdict reached (sticky until rst)
//   failed            FAIL or TIMEOUT (sticky until rst)
//   timed_out         watchdog expired (sticky until rst)
// -----------------------------------------------------------------------------
module ccsds_axis_golden_checker #(
    parameter int DATA_WIDTH     = 64,
    parameter int EXPECTED_WORDS = 12552,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] dut_data,
    input  logic                  dut_valid,
    input  logic                  dut_last,
    output logic                  dut_ready,
    input  logic [DATA_WIDTH-1:0] gold_data,
    input  logic                  gold_valid,
    output logic                  gold_ready,
    output logic [CNT_WIDTH-1:0]  words_checked,
    output logic [CNT_WIDTH-1:0]  mismatches,
    output logic [CNT_WIDTH-1:0]  first_err_index,
    output logic [DATA_WIDTH-1:0] first_err_dut,
    output logic                  length_err,
    output logic                  done,
    output logic                  failed,
    output logic                  timed_out
);

    typedef enum logic [1:0] {
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_t;

    // Word count compared one bit wider so the post-increment count never wraps.
    localparam logic [CNT_WIDTH:0]   EXP_N      = (CNT_WIDTH+1)'(EXPECTED_WORDS);
    localparam bit                   WDOG_EN    = (TIMEOUT_CYCLES > 0);
    // Expiry fires on the idle cycle that would bring the count to TIMEOUT_CYCLES.
    localparam logic [CNT_WIDTH-1:0] IDLE_LIMIT = WDOG_EN ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

    state_t                 state;
    state_t                 state_next;
    logic [CNT_WIDTH-1:0]   idle_cnt;

    logic                   both_valid;
    logic                   xfer;
    logic                   mismatch_now;
    logic                   any_mismatch;
    logic [CNT_WIDTH:0]     word_n;
    logic                   at_expected;
    logic                   length_err_set;

    assign both_valid   = dut_valid & gold_valid;
    assign mismatch_now = (dut_data != gold_data);
    assign any_mismatch = (mismatches != '0) | mismatch_now;
    assign word_n       = {1'b0, words_checked} + (CNT_WIDTH+1)'(1);
    assign at_expected  = (word_n == EXP_N);

    // -------------------------------------------------------------------------
    // Verdict FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RUN;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Verdict FSM: next state, handshake and transfer qualification
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        state_next     = state;
        dut_ready      = 1'b0;
        gold_ready     = 1'b0;
        xfer           = 1'b0;
        length_err_set = 1'b0;

        case (state)
            S_RUN: begin
                // Both streams are consumed together, so ready follows the
                // joined valid; the sources never look at ready first.
                dut_ready  = both_valid;
                gold_ready = both_valid;
                xfer       = both_valid;
                if (both_valid) begin
                    if (dut_last && at_expected) begin
                        state_next = any_mismatch ? S_FAIL : S_PASS;
                    end else if (dut_last || at_expected) begin
                        // Early last, or the expected count reached without last.
                        state_next     = S_FAIL;
                        length_err_set = 1'b1;
                    end
                end else if (WDOG_EN && (idle_cnt == IDLE_LIMIT)) begin
                    state_next = S_TIMEOUT;
                end
            end
            default: begin
                // Terminal: let the core drain, hold the golden source.
                dut_ready = 1'b1;
            end
        endcase

        if (rst) begin
            dut_ready  = 1'b0;
            gold_ready = 1'b0;
            xfer       = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Counters, first-error capture, watchdog, length flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            words_checked   <= '0;
            mismatches      <= '0;
            first_err_index <= '0;
            first_err_dut   <= '0;
            idle_cnt        <= '0;
            length_err      <= 1'b0;
        end else begin
            if (xfer) begin
                idle_cnt <= '0;
                if (!(&words_checked)) begin
                    words_checked <= words_checked + CNT_WIDTH'(1);
                end
                if (mismatch_now) begin
                    if (!(&mismatches)) begin
                        mismatches <= mismatches + CNT_WIDTH'(1);
                    end
                    // A saturated count never returns to zero, so this
                    // captures the first mismatch only.
                    if (mismatches == '0) begin
                        first_err_index <= words_checked;
                        first_err_dut   <= dut_data;
                    end
                end
            end else if (state == S_RUN) begin
                idle_cnt <= WDOG_EN ? idle_cnt + CNT_WIDTH'(1) : '0;
            end else begin
                idle_cnt <= '0;
            end

            if (length_err_set) begin
                length_err <= 1'b1;
            end
        end
    end

    // Flags decode the registered state, so they are registered outputs.
    assign done      = (state != S_RUN);
    assign failed    = (state == S_FAIL) || (state == S_TIMEOUT);
    assign timed_out = (state == S_TIMEOUT);

endmodule

// File: tb/tb_ccsds_axis_golden_checker.sv
// -----------------------------------------------------------------------------
// tb_ccsds_axis_golden_checker
//
// Directed bench for ccsds_axis_golden_checker with EXPECTED_WORDS=16 and
// TIMEOUT_CYCLES=100. Inputs change on the falling edge; outputs are sampled
// on the falling edge after the active rising edge. Each expected transfer
// pushes its predicted counter values to a queue, which is popped and
// compared once the transfer edge has passed.
// -----------------------------------------------------------------------------
module tb_ccsds_axis_golden_checker;

    localparam int DW  = 64;
    localparam int CW  = 32;
    localparam int EXP = 16;
    localparam int TO  = 100;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] dut_data;
    logic          dut_valid;
    logic          dut_last;
    logic          dut_ready;
    logic [DW-1:0] gold_data;
    logic          gold_valid;
    logic          gold_ready;
    logic [CW-1:0] words_checked;
    logic [CW-1:0] mismatches;
    logic [CW-1:0] first_err_index;
    logic [DW-1:0] first_err_dut;
    logic          length_err;
    logic          done;
    logic          failed;
    logic          timed_out;

    always #5 clk = ~clk;

    ccsds_axis_golden_checker #(
        .DATA_WIDTH    (DW),
        .EXPECTED_WORDS(EXP),
        .TIMEOUT_CYCLES(TO),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .dut_data       (dut_data),
        .dut_valid      (dut_valid),
        .dut_last       (dut_last),
        .dut_ready      (dut_ready),
        .gold_data      (gold_data),
        .gold_valid     (gold_valid),
        .gold_ready     (gold_ready),
        .words_checked  (words_checked),
        .mismatches     (mismatches),
        .first_err_index(first_err_index),
        .first_err_dut  (first_err_dut),
        .length_err     (length_err),
        .done           (done),
        .failed         (failed),
        .timed_out      (timed_out)
    );

    typedef struct packed {
        logic [CW-1:0] wc;
        logic [CW-1:0] mm;
    } sb_t;

    sb_t sb_q[$];

    int errors = 0;
    int checks = 0;

    // Reference model state.
    int            exp_wc;
    int            exp_mm;
    int            exp_fidx;
    logic [DW-1:0] exp_fdut;
    bit            exp_run;

    function automatic logic [DW-1:0] pat(input int i);
        return 64'h1357_9BDF_0000_0000 + 64'(i) * 64'h0000_0001_0101_0101;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Advance one cycle; compare any transfer predicted for that edge.
    task automatic tick();
        sb_t e;
        @(posedge clk);
        @(negedge clk);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("words_checked", 64'(words_checked), 64'(e.wc));
            check("mismatches", 64'(mismatches), 64'(e.mm));
        end
    endtask

    // Predict the effect of one transfer and queue the expected counters.
    task automatic model_xfer(input logic [DW-1:0] d, input logic [DW-1:0] g, input logic l);
        sb_t e;
        if (d != g) begin
            if (exp_mm == 0) begin
                exp_fidx = exp_wc;
                exp_fdut = d;
            end
            exp_mm++;
        end
        exp_wc++;
        e.wc = CW'(exp_wc);
        e.mm = CW'(exp_mm);
        sb_q.push_back(e);
        if (l || exp_wc == EXP) exp_run = 1'b0;
    endtask

    task automatic reset_dut();
        rst        = 1'b1;
        dut_valid  = 1'b1;
        gold_valid = 1'b1;
        dut_last   = 1'b0;
        dut_data   = '0;
        gold_data  = '0;
        sb_q.delete();
        #1;
        check("rst_dut_ready", 64'(dut_ready), 64'd0);
        check("rst_gold_ready", 64'(gold_ready), 64'd0);
        tick();
        rst        = 1'b0;
        dut_valid  = 1'b0;
        gold_valid = 1'b0;
        exp_wc     = 0;
        exp_mm     = 0;
        exp_fidx   = 0;
        exp_fdut   = '0;
        exp_run    = 1'b1;
        check("rst_words_checked", 64'(words_checked), 64'd0);
        check("rst_mismatches", 64'(mismatches), 64'd0);
        check("rst_first_err_index", 64'(first_err_index), 64'd0);
        check("rst_first_err_dut", first_err_dut, 64'd0);
        check("rst_length_err", 64'(length_err), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_failed", 64'(failed), 64'd0);
        check("rst_timed_out", 64'(timed_out), 64'd0);
    endtask

    // One word with both sources valid in the same cycle.
    task automatic drive_word(input logic [DW-1:0] d, input logic [DW-1:0] g, input logic l);
        bit run_before;
        run_before = exp_run;
        dut_valid  = 1'b1;
        gold_valid = 1'b1;
        dut_data   = d;
        gold_data  = g;
        dut_last   = l;
        if (run_before) model_xfer(d, g, l);
        #1;
        check("gold_ready", 64'(gold_ready), 64'(run_before));
        tick();
        check("done_track", 64'(done), 64'(!exp_run));
        dut_valid  = 1'b0;
        gold_valid = 1'b0;
        dut_last   = 1'b0;
    endtask

    task automatic check_verdict(input string tag, input logic d, input logic f,
                                 input logic le, input logic to);
        check({tag, "_done"}, 64'(done), 64'(d));
        check({tag, "_failed"}, 64'(failed), 64'(f));
        check({tag, "_length_err"}, 64'(length_err), 64'(le));
        check({tag, "_timed_out"}, 64'(timed_out), 64'(to));
        check({tag, "_words_checked"}, 64'(words_checked), 64'(exp_wc));
        check({tag, "_mismatches"}, 64'(mismatches), 64'(exp_mm));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=no_finish required=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int i;
        int cyc;
        bit gv_exp;

        // 1: identical 16-word streams, last on word 15 -> PASS.
        reset_dut();
        for (int k = 0; k < EXP; k++) drive_word(pat(k), pat(k), 1'(k == EXP - 1));
        check_verdict("t1", 1'b1, 1'b0, 1'b0, 1'b0);
        dut_valid  = 1'b1;
        gold_valid = 1'b1;
        #1;
        check("t1_drain_dut_ready", 64'(dut_ready), 64'd1);
        check("t1_hold_gold_ready", 64'(gold_ready), 64'd0);
        tick();
        check("t1_no_extra_count", 64'(words_checked), 64'(EXP));
        dut_valid  = 1'b0;
        gold_valid = 1'b0;

        // 2: word 5 differs -> FAIL with first error captured.
        reset_dut();
        for (int k = 0; k < EXP; k++) begin
            if (k == 5) drive_word(64'hDEAD, 64'hBEEF, 1'b0);
            else        drive_word(pat(k), pat(k), 1'(k == EXP - 1));
        end
        check_verdict("t2", 1'b1, 1'b1, 1'b0, 1'b0);
        check("t2_first_err_index", 64'(first_err_index), 64'd5);
        check("t2_first_err_dut", first_err_dut, 64'hDEAD);
        check("t2_model_index", 64'(first_err_index), 64'(exp_fidx));

        // 3: last on word 9 of 16 -> FAIL, length error, 10 words.
        reset_dut();
        for (int k = 0; k < 10; k++) drive_word(pat(k), pat(k), 1'(k == 9));
        check_verdict("t3", 1'b1, 1'b1, 1'b1, 1'b0);
        check("t3_words", 64'(words_checked), 64'd10);

        // 4: golden valid toggles randomly, DUT valid held high.
        reset_dut();
        i   = 0;
        cyc = 0;
        while (i < EXP && cyc < 400) begin
            dut_valid  = 1'b1;
            gold_valid = 1'($urandom_range(0, 1));
            dut_data   = pat(i);
            gold_data  = pat(i);
            dut_last   = 1'(i == EXP - 1);
            gv_exp     = gold_valid && exp_run;
            if (gv_exp) begin
                model_xfer(pat(i), pat(i), dut_last);
                i++;
            end
            #1;
            check("t4_gold_ready", 64'(gold_ready), 64'(gv_exp));
            check("t4_dut_ready", 64'(dut_ready), 64'(gv_exp));
            tick();
            cyc++;
        end
        dut_valid  = 1'b0;
        gold_valid = 1'b0;
        dut_last   = 1'b0;
        check("t4_budget", 64'(i), 64'(EXP));
        check_verdict("t4", 1'b1, 1'b0, 1'b0, 1'b0);
        check("t4_words", 64'(words_checked), 64'd16);

        // 5: DUT stops after 4 words -> TIMEOUT exactly 100 cycles later.
        reset_dut();
        for (int k = 0; k < 4; k++) drive_word(pat(k), pat(k), 1'b0);
        for (int k = 0; k < TO - 1; k++) tick();
        check("t5_not_yet_timed_out", 64'(timed_out), 64'd0);
        check("t5_not_yet_done", 64'(done), 64'd0);
        tick();
        check_verdict("t5", 1'b1, 1'b1, 1'b0, 1'b1);
        dut_valid = 1'b1;
        gold_valid = 1'b1;
        #1;
        check("t5_drain_dut_ready", 64'(dut_ready), 64'd1);
        check("t5_hold_gold_ready", 64'(gold_ready), 64'd0);
        dut_valid  = 1'b0;
        gold_valid = 1'b0;

        // 6: reset after 8 words with 2 mismatches, then a clean rerun.
        reset_dut();
        for (int k = 0; k < 8; k++) begin
            if (k == 2 || k == 6) drive_word(pat(k), ~pat(k), 1'b0);
            else                  drive_word(pat(k), pat(k), 1'b0);
        end
        check("t6_mid_mismatches", 64'(mismatches), 64'd2);
        check("t6_mid_first_idx", 64'(first_err_index), 64'd2);
        check("t6_mid_first_dut", first_err_dut, pat(2));
        check("t6_mid_done", 64'(done), 64'd0);
        reset_dut();
        for (int k = 0; k < EXP; k++) drive_word(pat(k), pat(k), 1'(k == EXP - 1));
        check_verdict("t6", 1'b1, 1'b0, 1'b0, 1'b0);

        // 7: expected count reached without last -> FAIL, length error.
        reset_dut();
        for (int k = 0; k < EXP; k++) drive_word(pat(k), pat(k), 1'b0);
        check_verdict("t7", 1'b1, 1'b1, 1'b1, 1'b0);

        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
